// File: rtl/sobol_sng_sink_if.sv
// Frame handoff bus from the Sobol stochastic-number sink to the arithmetic datapath.
// The master presents a packed bitstream with its ones-count under valid/ready.
interface sobol_sng_sink_if #(
    parameter int unsigned FRAME = 32,
    parameter int unsigned CW    = 6
);
    logic             bs_valid;
    logic             bs_ready;
    logic [FRAME-1:0] bs_data;
    logic [CW-1:0]    ones;

    modport master (output bs_valid, output bs_data, output ones, input bs_ready);
    modport slave  (input bs_valid, input bs_data, input ones, output bs_ready);
endinterface

// File: rtl/sobol_sng_sink.sv
// Sobol stream consumer: compares each generator value against a latched operand and packs
// one stochastic bit per strobe into a FRAME-bit word with its ones-count.
module sobol_sng_sink #(
    parameter int unsigned VW    = 6,
    parameter int unsigned FRAME = 32,
    parameter int unsigned CW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [VW-1:0] x,
    output logic          gen_en,
    input  logic          sob_en,
    input  logic [VW-1:0] sob_val,
    output logic          busy,
    output logic          ovf,
    sobol_sng_sink_if.master bs
);
    localparam int unsigned IW = $clog2(FRAME);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e           state_q, state_d;
    logic [VW-1:0]    x_lat_q, x_lat_d;
    logic [FRAME-1:0] data_q, data_d;
    logic [CW-1:0]    ones_q, ones_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             strobe_bit;

    assign strobe_bit = (sob_val < x_lat_q);

    always_comb begin
        state_d = state_q;
        x_lat_d = x_lat_q;
        data_d  = data_q;
        ones_d  = ones_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_lat_d = x;
                    data_d  = '0;
                    ones_d  = '0;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = StRun;
                end else if (sob_en) begin
                    ovf_d = 1'b1;
                end
            end
            StRun: begin
                // start is ignored here: the operand stays fixed for the whole frame
                if (sob_en) begin
                    data_d[idx_q] = strobe_bit;
                    ones_d        = ones_q + CW'(strobe_bit);
                    if (idx_q == IW'(FRAME - 1)) begin
                        idx_d   = '0;
                        state_d = StHold;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            StHold: begin
                if (sob_en) begin
                    ovf_d = 1'b1;
                end
                if (bs.bs_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_lat_q <= '0;
            data_q  <= '0;
            ones_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_lat_q <= x_lat_d;
            data_q  <= data_d;
            ones_q  <= ones_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decode straight from state so gen_en and bs_valid track it with no extra lag
    assign gen_en      = (state_q == StRun);
    assign busy        = (state_q == StRun) || (state_q == StHold);
    assign bs.bs_valid = (state_q == StHold);
    assign bs.bs_data  = data_q;
    assign bs.ones     = ones_q;
    assign ovf         = ovf_q;
endmodule

// File: tb/tb_sobol_sng_sink.sv
// Bench for sobol_sng_sink: plays the Sobol generator and the downstream consumer, checking
// frames against constant vectors and a per-strobe comparison model.
module tb_sobol_sng_sink;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] x = '0;
    logic       gen_en;
    logic       sob_en = 1'b0;
    logic [5:0] sob_val = '0;
    logic       busy;
    logic       ovf;

    sobol_sng_sink_if #(.FRAME(32), .CW(6)) bs ();

    sobol_sng_sink #(.VW(6), .FRAME(32), .CW(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .gen_en  (gen_en),
        .sob_en  (sob_en),
        .sob_val (sob_val),
        .busy    (busy),
        .ovf     (ovf),
        .bs      (bs)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [5:0] vals [32];

    typedef struct {
        logic [5:0]  xv;
        int          kind;  // 0 evens ascending, 1 evens descending, 2 Sobol order
        logic [31:0] ed;
        logic [5:0]  eo;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic load_vals(input int kind);
        for (int i = 0; i < 32; i++) begin
            int g;
            logic [5:0] r;
            if (kind == 0) vals[i] = 6'(2 * i);
            else if (kind == 1) vals[i] = 6'(62 - 2 * i);
            else begin
                // Gray-code index, bit-reversed into 6 bits: first Sobol dimension
                g = i ^ (i >> 1);
                for (int b = 0; b < 6; b++) r[5 - b] = g[b];
                vals[i] = r;
            end
        end
    endtask

    task automatic model(input logic [5:0] xv, output logic [31:0] d, output logic [5:0] o);
        d = '0;
        o = '0;
        for (int i = 0; i < 32; i++) begin
            if (vals[i] < xv) begin
                d[i] = 1'b1;
                o    = o + 6'd1;
            end
        end
    endtask

    task automatic run_frame(input logic [5:0] xv, input logic [31:0] ed, input logic [5:0] eo,
                             input int gapmax, input int rdy, input int mid_at,
                             input logic [5:0] mx, input bit start_on_ack, input bit hold_strobe);
        @(negedge clk);
        start = 1'b1;
        x     = xv;
        @(negedge clk);
        start = 1'b0;
        x     = 6'($urandom);
        check("gen_en_after_start", 32'(gen_en), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);
        check("ovf_cleared_by_start", 32'(ovf), 32'd0);
        for (int i = 0; i < 32; i++) begin
            if (i == mid_at) begin
                start = 1'b1;
                x     = mx;
            end
            sob_en  = 1'b1;
            sob_val = vals[i];
            if (i == 31) check("valid_before_last_edge", 32'(bs.bs_valid), 32'd0);
            @(negedge clk);
            start  = 1'b0;
            sob_en = 1'b0;
            if (i < 31) repeat ($urandom_range(0, gapmax)) @(negedge clk);
        end
        check("valid_one_cycle_after", 32'(bs.bs_valid), 32'd1);
        check("gen_en_drop", 32'(gen_en), 32'd0);
        check("ovf_in_hold", 32'(ovf), 32'd0);
        check("bs_data", bs.bs_data, ed);
        check("ones", 32'(bs.ones), 32'(eo));
        for (int r = 0; r < rdy; r++) begin
            if (r == 0 && hold_strobe) begin
                sob_en  = 1'b1;
                sob_val = 6'($urandom);
            end
            @(negedge clk);
            sob_en = 1'b0;
            check("stall_valid", 32'(bs.bs_valid), 32'd1);
            check("stall_data", bs.bs_data, ed);
            check("stall_ones", 32'(bs.ones), 32'(eo));
        end
        if (hold_strobe) check("ovf_from_hold", 32'(ovf), 32'd1);
        bs.bs_ready = 1'b1;
        if (start_on_ack) begin
            start = 1'b1;
            x     = mx;
        end
        @(negedge clk);
        bs.bs_ready = 1'b0;
        start       = 1'b0;
        check("valid_after_ack", 32'(bs.bs_valid), 32'd0);
        check("busy_after_ack", 32'(busy), 32'd0);
        check("gen_en_after_ack", 32'(gen_en), 32'd0);
        if (start_on_ack) begin
            @(negedge clk);
            check("ack_start_ignored", 32'(busy), 32'd0);
            check("ack_start_data_kept", bs.bs_data, ed);
        end
    endtask

    initial begin
        logic [31:0] md;
        logic [5:0]  mo;
        logic [5:0]  rx;
        bs.bs_ready = 1'b0;

        tbl[0] = '{xv: 6'd0,  kind: 0, ed: 32'h0000_0000, eo: 6'd0};
        tbl[1] = '{xv: 6'd63, kind: 0, ed: 32'hFFFF_FFFF, eo: 6'd32};
        tbl[2] = '{xv: 6'd16, kind: 2, ed: 32'h8181_8181, eo: 6'd8};
        tbl[3] = '{xv: 6'd63, kind: 2, ed: 32'hFFFF_FFFF, eo: 6'd32};
        tbl[4] = '{xv: 6'd16, kind: 0, ed: 32'h0000_00FF, eo: 6'd8};
        tbl[5] = '{xv: 6'd33, kind: 0, ed: 32'h0001_FFFF, eo: 6'd17};
        tbl[6] = '{xv: 6'd16, kind: 1, ed: 32'hFF00_0000, eo: 6'd8};
        tbl[7] = '{xv: 6'd0,  kind: 2, ed: 32'h0000_0000, eo: 6'd0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_gen_en", 32'(gen_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(bs.bs_valid), 32'd0);
        check("rst_data", bs.bs_data, 32'd0);
        check("rst_ones", 32'(bs.ones), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        for (int i = 0; i < 8; i++) begin
            load_vals(tbl[i].kind);
            run_frame(tbl[i].xv, tbl[i].ed, tbl[i].eo, (i % 2) * 2, (i == 2) ? 5 : i % 3,
                      -1, 6'd0, 1'b0, 1'b0);
        end

        // Strobe in IDLE sets ovf and leaves the held frame untouched
        @(negedge clk);
        sob_en  = 1'b1;
        sob_val = 6'd5;
        @(negedge clk);
        sob_en = 1'b0;
        check("ovf_from_idle", 32'(ovf), 32'd1);
        check("idle_strobe_data", bs.bs_data, tbl[7].ed);
        check("idle_strobe_busy", 32'(busy), 32'd0);

        // Strobe in HOLD; the start inside run_frame clears the earlier ovf
        load_vals(2);
        run_frame(6'd16, 32'h8181_8181, 6'd8, 0, 3, -1, 6'd0, 1'b0, 1'b1);

        // start while RUN with a different operand is ignored
        run_frame(6'd16, 32'h8181_8181, 6'd8, 1, 1, 5, 6'd63, 1'b0, 1'b0);

        // start coincident with the accepting bs_ready completes the frame only
        load_vals(0);
        run_frame(6'd33, 32'h0001_FFFF, 6'd17, 0, 2, -1, 6'd63, 1'b1, 1'b0);

        // Reset after 10 strobes discards the partial frame
        @(negedge clk);
        start = 1'b1;
        x     = 6'd63;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sob_en  = 1'b1;
            sob_val = vals[i];
            @(negedge clk);
        end
        sob_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_gen_en", 32'(gen_en), 32'd0);
        check("midrst_ones", 32'(bs.ones), 32'd0);
        check("midrst_valid", 32'(bs.bs_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", bs.bs_data, 32'd0);
        run_frame(6'd63, 32'hFFFF_FFFF, 6'd32, 0, 0, -1, 6'd0, 1'b0, 1'b0);

        // Random operands, values, strobe spacing and back-pressure against the model
        for (int n = 0; n < 20; n++) begin
            rx = 6'($urandom_range(0, 63));
            for (int i = 0; i < 32; i++) vals[i] = 6'($urandom);
            model(rx, md, mo);
            run_frame(rx, md, mo, 3, $urandom_range(0, 4), -1, 6'd0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sobol_sng_sink.md
Name: sobol_sng_sink

Overview:
- Consumer end of the Sobol generator stream.
- Drives the generator's enable and receives its one-cycle (en, 6-bit value) strobes.
- Compares each value against a latched 6-bit operand, producing one stochastic bit per strobe.
- Packs 32 bits into a frame with a ones-count and hands the frame downstream over a valid/ready handshake. Sits between the Sobol generator and the stochastic arithmetic datapath.

Parameters:
- VW, 6, width of Sobol values and of the operand.
- FRAME, 32, bits per frame; must equal the generator period.
- CW, 6, ones-count width; holds 0..FRAME.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; latches x and begins a frame
- x  in  VW  operand value, sampled only on an accepted start
- gen_en  out  1  enable to the Sobol generator (its en_in)
- sob_en  in  1  value strobe from the generator (its en_out)
- sob_val  in  VW  Sobol value, valid when sob_en=1
- busy  out  1  high in RUN and HOLD
- bs_valid  out  1  frame available
- bs_ready  in  1  downstream accepts the frame
- bs_data  out  FRAME  bitstream; bit i comes from the i-th accepted strobe
- ones  out  CW  number of 1s in bs_data
- ovf  out  1  sticky flag: a strobe arrived outside RUN

Behaviour:
- Interface: one clock domain (clk). Reset is synchronous and active-high (rst).
- Reset (rst=1 at a clk edge, including mid-frame):
  - state=IDLE.
  - gen_en, busy, bs_valid, ovf = 0.
  - bs_data = 0, ones = 0, internal index = 0, x_lat = 0.
  - Any in-progress frame is discarded.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - gen_en=0.
  - start=1: x_lat<=x, bs_data<=0, ones<=0, idx<=0, ovf<=0, next state RUN.
  - gen_en=1 from the following cycle, so the generator restarts from its first point.
- RUN:
  - gen_en=1, busy=1.
  - On sob_en=1: bit = (sob_val < x_lat), unsigned compare.
  - bs_data[idx] <= bit; ones <= ones + bit; idx <= idx+1.
  - When the strobe has idx==FRAME-1: next state HOLD, idx wraps to 0.
  - gen_en drops in the cycle after that 32nd strobe.
- HOLD:
  - gen_en=0, bs_valid=1.
  - bs_data and ones are held stable while bs_ready=0.
  - On bs_valid & bs_ready: bs_valid<=0, state IDLE.
  - bs_valid rises exactly 1 cycle after the clk edge that accepted the 32nd strobe.
- start while busy: ignored; x_lat unchanged.
- sob_en in IDLE or HOLD: value dropped, ovf<=1.
  - ovf stays set until the next accepted start or reset.
  - The final strobe in RUN (the one that moves to HOLD) does not set ovf.
- start and bs_ready in the same HOLD cycle: the frame completes, start is ignored, and the next start is accepted only from IDLE.
- Arithmetic:
  - ones saturates logically at FRAME; no wrap is possible because there are exactly FRAME increments per frame.
  - x_lat=0 gives all-zero bits.
  - x_lat=2^VW-1 gives 0 only where sob_val=2^VW-1.
- The generator's strobe gaps are arbitrary; the block makes no assumption on strobe spacing (back-to-back strobes accepted).

Test Plan:
- x=0, start, drive 32 strobes with values 0,2,4..62 (any order) → bs_data=0x00000000, ones=0, bs_valid 1 cycle after the 32nd strobe.
- x=63, same 32 values → bs_data=0xFFFFFFFF, ones=32.
- x=16, strobes 0,32,48,16,24,56,40,8,... (standard 6-bit Sobol, 32 points) → ones=8. Each bs_data bit equals (value<16) in strobe order.
- Frame complete with bs_ready held 0 for 5 cycles → bs_valid, bs_data and ones stable for all 5 cycles. The handshake completes on the cycle bs_ready=1, then the block returns to IDLE with gen_en=0.
- sob_en pulsed in IDLE and in HOLD → ovf=1 and bs_data unchanged. Next start clears ovf to 0.
- rst=1 after 10 strobes in RUN → the next cycle shows IDLE, gen_en=0, ones=0, bs_valid=0. A new start with x=63 and 32 strobes yields ones=32 (no stale bits).
- start pulsed in RUN with a different x → ignored; the frame result matches the originally latched x.
